crc_feeder: RTL and testbench

CRC_FEEDER -- requirements
Module: crc_feeder

---
 rtl/crc_pkg.sv | 40 ++++
 rtl/crc_feeder_if.sv | 24 ++
 rtl/crc_feeder_fifo.sv | 59 +++++
 rtl/crc_feeder.sv | 98 +++++++++
 tb/tb_crc_feeder.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC feeder: FSM states, size codes,
// register-select codes and the size-to-lane mapping.
package crc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StHold,
    StWait
  } state_e;

  typedef enum logic [1:0] {
    Size8    = 2'b00,
    Size16   = 2'b01,
    Size32   = 2'b10,
    SizeRsvd = 2'b11
  } size_e;

  localparam logic [1:0] RsData = 2'b10;
  localparam logic [1:0] RsRefl = 2'b11;

  typedef struct packed {
    logic        reflect;
    logic [1:0]  size;
    logic [31:0] data;
  } entry_t;

  // Byte lanes are LSB first, so wider sizes just add higher lanes.
  function automatic logic [3:0] size_to_wrl(input logic [1:0] size);
    logic [3:0] wrl;
    case (size)
      Size8:   wrl = 4'b0001;
      Size16:  wrl = 4'b0011;
      Size32:  wrl = 4'b1111;
      default: wrl = 4'b0000;
    endcase
    return wrl;
  endfunction

endpackage

// File: rtl/crc_feeder_if.sv
// Bus-side push port of the CRC feeder.
interface crc_feeder_if;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic [1:0]  wr_size;
  logic        wr_reflect;
  logic        wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_size,
    output wr_reflect,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_size,
    input  wr_reflect,
    output wr_ready
  );
endinterface

// File: rtl/crc_feeder_fifo.sv
// Synchronous FIFO of feeder entries; storage is not reset, only pointers/level.
module crc_feeder_fifo
  import crc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   push_entry,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;

  // Storage write; no reset needed since level gates what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign level = count;
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/crc_feeder.sv
// Queues bus writes and replays them to a CRC engine as single-cycle strobes,
// pacing each transfer on the engine's terminal-count flag.
module crc_feeder
  import crc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  crc_feeder_if.slave            bus,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err,
  output logic                   idle,
  output logic                   done,
  output logic                   crc_wr,
  output logic [1:0]             crc_rs,
  output logic [3:0]             crc_wrl,
  output logic [31:0]            crc_d,
  input  logic                   crc_ready
);

  state_e      state_q, state_d;
  entry_t      head, push_entry;
  logic        full, empty, rsvd, push, pop;
  logic        err_q, idle_q;
  logic [31:0] crc_d_q;
  logic [1:0]  crc_rs_q;
  logic [3:0]  crc_wrl_q;

  assign bus.wr_ready = ~full;
  assign rsvd         = (bus.wr_size == SizeRsvd);
  assign push         = bus.wr_valid & ~full & ~flush & ~rsvd;
  assign pop          = (state_q == StIdle) & ~empty & crc_ready & ~flush;
  assign push_entry   = '{reflect: bus.wr_reflect, size: bus.wr_size, data: bus.wr_data};

  crc_feeder_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_entry(push_entry),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // Next state; an in-flight strobe is never cut short by flush.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pop) state_d = StIssue;
      StIssue: state_d = StHold;
      StHold:  state_d = flush ? StIdle : StWait;
      StWait:  if (flush || crc_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, output word registers, sticky error and idle history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      crc_d_q   <= '0;
      crc_rs_q  <= RsData;
      crc_wrl_q <= '0;
      err_q     <= 1'b0;
      idle_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle;
      if (pop) begin
        crc_d_q   <= head.data;
        crc_rs_q  <= head.reflect ? RsRefl : RsData;
        crc_wrl_q <= size_to_wrl(head.size);
      end
      if (flush) begin
        err_q <= 1'b0;
      end else if (bus.wr_valid && !full && rsvd) begin
        err_q <= 1'b1;
      end
    end
  end

  assign crc_wr  = (state_q == StIssue);
  assign crc_d   = crc_d_q;
  assign crc_rs  = crc_rs_q;
  assign crc_wrl = crc_wrl_q;
  assign err     = err_q;
  assign idle    = empty & (state_q == StIdle) & crc_ready;
  // Masked during reset so the pulse cannot appear while everything is cleared.
  assign done    = idle & ~idle_q & ~reset;

endmodule

// File: tb/tb_crc_feeder.sv
// Bench for crc_feeder: scoreboarded strobes, a CRC-32 engine model and
// directed plus randomized push traffic.
module tb_crc_feeder;
  import crc_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        crc_ready = 1'b1;
  logic [2:0]  level;
  logic        err, idle, done, crc_wr;
  logic [1:0]  crc_rs;
  logic [3:0]  crc_wrl;
  logic [31:0] crc_d;

  crc_feeder_if bus ();

  crc_feeder #(
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .flush    (flush),
    .level    (level),
    .err      (err),
    .idle     (idle),
    .done     (done),
    .crc_wr   (crc_wr),
    .crc_rs   (crc_rs),
    .crc_wrl  (crc_wrl),
    .crc_d    (crc_d),
    .crc_ready(crc_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  rs;
    logic [3:0]  wrl;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          strobes = 0;
  int          pushed = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          busy_len = 8;
  bit          hold = 1'b0;
  logic [31:0] eng_crc = 32'hFFFF_FFFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  // Expected engine write: lanes are the low 2**size bytes.
  function automatic exp_t mk_exp(input logic [31:0] d, input int size, input bit refl);
    exp_t e;
    e.d   = d;
    e.rs  = refl ? 2'b11 : 2'b10;
    e.wrl = 4'((1 << (1 << size)) - 1);
    return e;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[31-i];
    return r;
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {b, 24'h0};
    for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
    return r;
  endfunction

  // CRC engine model: consumes each strobe, then stays busy for busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt  = 0;
        crc_ready = !hold;
      end else begin
        if (crc_wr) begin
          chk("strobe_while_busy", 32'(busy_cnt == 0 && !hold), 1);
          for (int b = 0; b < $countones(crc_wrl); b++) begin
            eng_crc = crc_byte(eng_crc, (crc_rs == 2'b11) ? rev8(crc_d[8*b+:8]) : crc_d[8*b+:8]);
          end
          busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
        end
        crc_ready = (busy_cnt == 0) && !hold;
      end
    end
  end

  // Monitor: compares every strobe against the scoreboard head.
  initial begin
    realtime last = -1000.0;
    exp_t    e;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        if (done) done_cnt++;
        if (crc_wr) begin
          strobes++;
          chk("strobe_gap", 32'(($realtime - last) >= 40.0), 1);
          last = $realtime;
          chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("crc_d", crc_d, e.d);
            chk("crc_rs", 32'(crc_rs), 32'(e.rs));
            chk("crc_wrl", 32'(crc_wrl), 32'(e.wrl));
          end
        end
      end
    end
  end

  // Called at a negedge: present one word for exactly one sampling edge.
  task automatic push_one(input logic [31:0] d, input logic [1:0] sz, input bit refl);
    bus.wr_valid   = 1'b1;
    bus.wr_data    = d;
    bus.wr_size    = sz;
    bus.wr_reflect = refl;
    @(negedge clk);
    bus.wr_valid   = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (idle && exp_q.size() == 0 && busy_cnt == 0) break;
    end
    chk("wait_idle", 32'(idle), 1);
  endtask

  initial begin
    string       msg;
    int          s0, gap, sz, done0;
    bit          any_rsvd;
    logic [31:0] d;

    msg = "123456789";
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.wr_size    = 2'b00;
    bus.wr_reflect = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_level", 32'(level), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_crc_wr", 32'(crc_wr), 0);
    chk("rst_crc_d", crc_d, 0);
    chk("rst_crc_rs", 32'(crc_rs), 2);
    chk("rst_crc_wrl", 32'(crc_wrl), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 1);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 32-bit normal word: strobe in the second cycle after the push edge.
    exp_q.push_back(mk_exp(32'h4433_2211, 2, 0));
    pushed++;
    bus.wr_valid   = 1'b1;
    bus.wr_data    = 32'h4433_2211;
    bus.wr_size    = 2'b10;
    bus.wr_reflect = 1'b0;
    @(posedge clk);
    #2;
    bus.wr_valid = 1'b0;
    chk("lat_cycle1_wr", 32'(crc_wr), 0);
    chk("lat_cycle1_level", 32'(level), 1);
    @(posedge clk);
    #2;
    chk("lat_cycle2_wr", 32'(crc_wr), 1);
    wait_idle();

    // Reflected byte followed by a queued halfword while the engine is busy.
    exp_q.push_back(mk_exp(32'h0000_00A5, 0, 1));
    push_one(32'h0000_00A5, 2'b00, 1'b1);
    exp_q.push_back(mk_exp(32'h1234_BEEF, 1, 0));
    push_one(32'h1234_BEEF, 2'b01, 1'b0);
    pushed += 2;
    wait_idle();

    // Engine held busy: six back-to-back pushes, only four fit.
    hold = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      d = 32'hC0DE_0000 + 32'(i);
      chk("full_level", 32'(level), (i < 4) ? 32'(i) : 32'd4);
      chk("full_ready", 32'(bus.wr_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) exp_q.push_back(mk_exp(d, 2, 0));
      push_one(d, 2'b10, 1'b0);
    end
    pushed += 4;
    chk("full_level_end", 32'(level), 4);
    chk("full_ready_end", 32'(bus.wr_ready), 0);
    hold = 1'b0;
    wait_idle();

    // Reserved size sets err and is dropped; flush clears queue and err.
    push_one(32'hDEAD_BEEF, 2'b11, 1'b0);
    chk("rsvd_err", 32'(err), 1);
    chk("rsvd_level", 32'(level), 0);
    hold = 1'b1;
    @(negedge clk);
    push_one(32'h1111_1111, 2'b10, 1'b0);
    push_one(32'h2222_2222, 2'b10, 1'b0);
    chk("pre_flush_level", 32'(level), 2);
    s0 = strobes;
    flush = 1'b1;
    push_one(32'h3333_3333, 2'b10, 1'b0);
    flush = 1'b0;
    chk("flush_level", 32'(level), 0);
    chk("flush_err", 32'(err), 0);
    hold = 1'b0;
    repeat (20) @(negedge clk);
    chk("flush_no_strobe", 32'(strobes), 32'(s0));
    pushed = strobes;

    // CRC-32 of "123456789" fed as reflected bytes.
    eng_crc = 32'hFFFF_FFFF;
    done0   = done_cnt;
    for (int i = 0; i < 9; i++) begin
      for (int w = 0; w < 500 && (pushed - strobes) >= DEPTH; w++) @(negedge clk);
      chk("crc_ready_room", 32'(bus.wr_ready), 1);
      exp_q.push_back(mk_exp({24'h0, msg[i]}, 0, 1));
      push_one({24'h0, msg[i]}, 2'b00, 1'b1);
      pushed++;
    end
    wait_idle();
    chk("crc32_check", rev32(eng_crc) ^ 32'hFFFF_FFFF, 32'hCBF4_3926);
    chk("crc32_done_once", 32'(done_cnt - done0), 1);

    // Randomized traffic with random engine latency.
    any_rsvd = 1'b0;
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      busy_len = $urandom_range(0, 6);
      for (int w = 0; w < 500 && (pushed - strobes) >= DEPTH; w++) @(negedge clk);
      chk("rnd_level", 32'(level), 32'(pushed - strobes));
      chk("rnd_ready", 32'(bus.wr_ready), 1);
      sz = $urandom_range(0, 3);
      d  = $urandom;
      if (sz == 3) begin
        any_rsvd = 1'b1;
        push_one(d, 2'b11, 1'b0);
      end else begin
        exp_q.push_back(mk_exp(d, sz, n[0]));
        push_one(d, 2'(sz), n[0]);
        pushed++;
      end
    end
    wait_idle();
    chk("rnd_err", 32'(err), 32'(any_rsvd));

    // Reset while waiting on the engine with three entries queued.
    busy_len = 8;
    for (int i = 0; i < 4; i++) begin
      d = 32'hABCD_0000 + 32'(i);
      exp_q.push_back(mk_exp(d, 2, 0));
      push_one(d, 2'b10, 1'b0);
    end
    chk("wait_level", 32'(level), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_level", 32'(level), 0);
    chk("abort_crc_wr", 32'(crc_wr), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    s0 = strobes;
    repeat (30) @(negedge clk);
    chk("abort_no_strobe", 32'(strobes), 32'(s0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
